// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranging front-end: trigger generation, echo timing in whole
// centimetres, distance-window qualification and a confirmed single-cycle detect.
module hcsr04_ranger #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned CYCLES_PER_CM  = 2941,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned PERIOD_CYCLES  = 3000000,
    parameter int unsigned NEAR_CM        = 95,
    parameter int unsigned FAR_CM         = 102,
    parameter int unsigned CONFIRM        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       echo,
    output logic       trig,
    output logic [8:0] distance_cm,
    output logic       dist_valid,
    output logic       timeout,
    output logic       in_window,
    output logic       detect,
    output logic       led
);

    localparam int PER_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SUB_W  = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
    localparam int CONF_W = $clog2(CONFIRM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t             state_q, state_d;
    logic               echo_m_q, echo_s_q;
    logic [PER_W-1:0]   per_q, per_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [8:0]         cm_q, cm_d;
    logic [CONF_W-1:0]  conf_q, conf_d;
    logic               trig_q, trig_d;
    logic [8:0]         dist_q, dist_d;
    logic               dist_valid_q, dist_valid_d;
    logic               timeout_q, timeout_d;
    logic               in_window_q, in_window_d;
    logic               detect_q, detect_d;

    logic               sub_wrap;
    logic [SUB_W-1:0]   sub_next;
    logic [8:0]         cm_next;
    logic               tmo_hit;
    logic               dist_in_range;

    // The cycle on which echo_s is seen low still counts, so an echo of exactly
    // CYCLES_PER_CM cycles completes its first centimetre.
    always_comb begin
        sub_wrap = (sub_q == SUB_W'(CYCLES_PER_CM - 1));
        sub_next = sub_wrap ? '0 : sub_q + SUB_W'(1);
        cm_next  = (sub_wrap && cm_q != 9'd511) ? cm_q + 9'd1 : cm_q;
        tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_d      = state_q;
        per_d        = (state_q == S_IDLE) ? per_q : per_q + PER_W'(1);
        tmo_d        = tmo_q + TMO_W'(1);
        sub_d        = sub_q;
        cm_d         = cm_q;
        trig_d       = trig_q;
        dist_d       = dist_q;
        dist_valid_d = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_TRIG;
                    per_d   = '0;
                    trig_d  = 1'b1;
                end
            end
            S_TRIG: begin
                if (per_q == PER_W'(TRIG_CYCLES - 1)) begin
                    state_d = S_WAIT_RISE;
                    trig_d  = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_WAIT_RISE: begin
                if (echo_s_q) begin
                    state_d = S_MEASURE;
                    cm_d    = '0;
                    sub_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    state_d   = S_HOLDOFF;
                    timeout_d = 1'b1;
                end
            end
            S_MEASURE: begin
                sub_d = sub_next;
                cm_d  = cm_next;
                if (!echo_s_q) begin
                    state_d      = S_HOLDOFF;
                    dist_d       = cm_next;
                    dist_valid_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d   = S_HOLDOFF;
                    timeout_d = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (per_q == PER_W'(PERIOD_CYCLES - 1)) begin
                    per_d = '0;
                    if (enable) begin
                        state_d = S_TRIG;
                        trig_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Confirmation is evaluated on the same edge as dist_valid so detect lines up with it.
    always_comb begin
        conf_d        = conf_q;
        in_window_d   = in_window_q;
        detect_d      = 1'b0;
        dist_in_range = (dist_d >= 9'(NEAR_CM)) && (dist_d <= 9'(FAR_CM));
        if (dist_valid_d) begin
            if (dist_in_range) begin
                in_window_d = 1'b1;
                if (conf_q != CONF_W'(CONFIRM)) begin
                    conf_d   = conf_q + CONF_W'(1);
                    detect_d = (conf_q == CONF_W'(CONFIRM - 1));
                end
            end else begin
                in_window_d = 1'b0;
                conf_d      = '0;
            end
        end
        if (timeout_d) begin
            in_window_d = 1'b0;
            conf_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            echo_m_q     <= 1'b0;
            echo_s_q     <= 1'b0;
            per_q        <= '0;
            tmo_q        <= '0;
            sub_q        <= '0;
            cm_q         <= '0;
            conf_q       <= '0;
            trig_q       <= 1'b0;
            dist_q       <= '0;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            in_window_q  <= 1'b0;
            detect_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            echo_m_q     <= echo;
            echo_s_q     <= echo_m_q;
            per_q        <= per_d;
            tmo_q        <= tmo_d;
            sub_q        <= sub_d;
            cm_q         <= cm_d;
            conf_q       <= conf_d;
            trig_q       <= trig_d;
            dist_q       <= dist_d;
            dist_valid_q <= dist_valid_d;
            timeout_q    <= timeout_d;
            in_window_q  <= in_window_d;
            detect_q     <= detect_d;
        end
    end

    assign trig        = trig_q;
    assign distance_cm = dist_q;
    assign dist_valid  = dist_valid_q;
    assign timeout     = timeout_q;
    assign in_window   = in_window_q;
    assign detect      = detect_q;
    assign led         = in_window_q;

endmodule
